// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pipe_ctrl_pkg - shared state encoding and constants for pipeline_controller|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      REDIRECT = 2'd2
   } pipe_ctrl_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/pipeline_controller_hazard_detect.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | hazard_detect - combinational load-use comparator between EX and ID       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1_address,
   input  logic [4:0] id_rs2_address,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd_address,
   input  logic       ex_reg_write,
   input  logic       ex_is_load,
   output logic       load_use
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = id_uses_rs1 && (id_rs1_address == ex_rd_address);
   assign rs2_match = id_uses_rs2 && (id_rs2_address == ex_rd_address);
   // x0 is hardwired, so a load targeting it never creates a dependency
   assign load_use  = ex_is_load && ex_reg_write && (ex_rd_address != REG_ZERO)
                      && (rs1_match || rs2_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pipeline_controller - stall/flush sequencer; PIPE_CTRL_PERF_EN adds perf  |
// | counters. Revision: 1.0                                                   |
// +---------------------------------------------------------------------------+
module pipeline_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        resetn,
   input  logic [4:0]  id_rs1_address,
   input  logic [4:0]  id_rs2_address,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd_address,
   input  logic        ex_reg_write,
   input  logic        ex_is_load,
   input  logic        ex_redirect,
   input  logic        mem_access_valid,
   input  logic        mem_ready,
   output logic        pc_enable,
   output logic        if_id_enable,
   output logic        if_id_flush,
   output logic        id_ex_enable,
   output logic        id_ex_flush,
   output logic        ex_mem_enable,
   output logic        mem_timeout_error
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
`endif
);

   localparam int              CNT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   pipe_ctrl_state_t state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic             load_use;
   logic             mem_stall;

   hazard_detect u_hazard_detect (
      .id_rs1_address (id_rs1_address),
      .id_rs2_address (id_rs2_address),
      .id_uses_rs1    (id_uses_rs1),
      .id_uses_rs2    (id_uses_rs2),
      .ex_rd_address  (ex_rd_address),
      .ex_reg_write   (ex_reg_write),
      .ex_is_load     (ex_is_load),
      .load_use       (load_use)
   );

   assign mem_stall = mem_access_valid && !mem_ready;

   always_comb begin
      state_d       = RUN;
      pc_enable     = 1'b1;
      if_id_enable  = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_enable  = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_enable = 1'b1;
      if (mem_stall) begin
         pc_enable     = 1'b0;
         if_id_enable  = 1'b0;
         id_ex_enable  = 1'b0;
         ex_mem_enable = 1'b0;
         // a pending wrong-path squash must survive the stall
         state_d       = (state_q == REDIRECT) ? REDIRECT : MEM_WAIT;
      end else if (state_q == REDIRECT) begin
         if_id_flush = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         state_d     = REDIRECT;
      end else if (load_use) begin
         pc_enable    = 1'b0;
         if_id_enable = 1'b0;
         id_ex_flush  = 1'b1;
      end
      if (!resetn) begin
         pc_enable     = 1'b0;
         if_id_enable  = 1'b0;
         if_id_flush   = 1'b0;
         id_ex_enable  = 1'b0;
         id_ex_flush   = 1'b0;
         ex_mem_enable = 1'b0;
      end
   end

   always_comb begin
      wait_cnt_d = '0;
      if ((state_q == MEM_WAIT) && mem_stall) begin
         wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
      end
      timeout_d = timeout_q || (wait_cnt_d == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign mem_timeout_error = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_events_q, flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (!pc_enable && resetn) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (if_id_flush || id_ex_flush) begin
         flush_events_d = flush_events_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pipeline_controller - directed vector bench for pipeline_controller    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_pipeline_controller;

   // expected enables/flushes: {pc, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en}
   localparam logic [5:0] E_RUN  = 6'b110101;
   localparam logic [5:0] E_STL  = 6'b000000;
   localparam logic [5:0] E_LU   = 6'b000111;
   localparam logic [5:0] E_RD1  = 6'b111111;
   localparam logic [5:0] E_RD2  = 6'b111101;

   typedef struct packed {
      logic       rstn;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       ld;
      logic       rdr;
      logic       mav;
      logic       mrdy;
      logic [5:0] exp;
      logic       err;
   } vec_t;

   logic       clk = 1'b0;
   logic       resetn;
   logic [4:0] id_rs1_address, id_rs2_address, ex_rd_address;
   logic       id_uses_rs1, id_uses_rs2, ex_reg_write, ex_is_load;
   logic       ex_redirect, mem_access_valid, mem_ready;
   logic       pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush;
   logic       ex_mem_enable, mem_timeout_error;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles, flush_events;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   pipeline_controller #(.MEM_TIMEOUT(2)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .id_rs1_address    (id_rs1_address),
      .id_rs2_address    (id_rs2_address),
      .id_uses_rs1       (id_uses_rs1),
      .id_uses_rs2       (id_uses_rs2),
      .ex_rd_address     (ex_rd_address),
      .ex_reg_write      (ex_reg_write),
      .ex_is_load        (ex_is_load),
      .ex_redirect       (ex_redirect),
      .mem_access_valid  (mem_access_valid),
      .mem_ready         (mem_ready),
      .pc_enable         (pc_enable),
      .if_id_enable      (if_id_enable),
      .if_id_flush       (if_id_flush),
      .id_ex_enable      (id_ex_enable),
      .id_ex_flush       (id_ex_flush),
      .ex_mem_enable     (ex_mem_enable),
      .mem_timeout_error (mem_timeout_error)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cycles      (stall_cycles),
      .flush_events      (flush_events)
`endif
   );

   function automatic vec_t v(input logic rstn, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic ld, input logic rdr,
                              input logic mav, input logic mrdy,
                              input logic [5:0] exp, input logic err);
      vec_t r;
      r.rstn = rstn; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
      r.rw = rw; r.ld = ld; r.rdr = rdr; r.mav = mav; r.mrdy = mrdy;
      r.exp = exp; r.err = err;
      return r;
   endfunction

   task automatic drive(input vec_t x);
      resetn           = x.rstn;
      id_rs1_address   = x.rs1;
      id_rs2_address   = x.rs2;
      id_uses_rs1      = x.u1;
      id_uses_rs2      = x.u2;
      ex_rd_address    = x.rd;
      ex_reg_write     = x.rw;
      ex_is_load       = x.ld;
      ex_redirect      = x.rdr;
      mem_access_valid = x.mav;
      mem_ready        = x.mrdy;
   endtask

   task automatic check(input string name, input logic [5:0] exp, input logic err);
      logic [6:0] act;
      act = {pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
             ex_mem_enable, mem_timeout_error};
      n_cmp++;
      if (act !== {exp, err}) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", name, act, {exp, err});
      end
   endtask

   initial begin
      //       rstn rs1   rs2   u1 u2 rd    rw ld rdr mav mrdy exp   err
      vq.push_back(v(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, E_STL, 0)); // 0 reset
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, E_RUN, 0)); // 1 idle
      vq.push_back(v(1, 5'd5, 5'd1, 1, 0, 5'd5, 1, 1, 0, 0, 0, E_LU,  0)); // 2 lw x5 -> rs1
      vq.push_back(v(1, 5'd5, 5'd1, 1, 0, 5'd0, 0, 0, 0, 1, 1, E_RUN, 0)); // 3 load in MEM
      vq.push_back(v(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0, E_RUN, 0)); // 4 rd=x0
      vq.push_back(v(1, 5'd7, 5'd7, 0, 1, 5'd7, 1, 1, 0, 0, 0, E_LU,  0)); // 5 rs2 match
      vq.push_back(v(1, 5'd7, 5'd7, 0, 0, 5'd7, 1, 1, 0, 0, 0, E_RUN, 0)); // 6 not used
      vq.push_back(v(1, 5'd7, 5'd2, 1, 1, 5'd7, 0, 1, 0, 0, 0, E_RUN, 0)); // 7 no reg_write
      vq.push_back(v(1, 5'd7, 5'd2, 1, 1, 5'd7, 1, 0, 0, 0, 0, E_RUN, 0)); // 8 not a load
      vq.push_back(v(1, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 1, 0, 0, E_RD1, 0)); // 9 redirect+lu
      vq.push_back(v(1, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 1, 0, 0, E_RD2, 0)); // 10 REDIRECT
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, E_RUN, 0)); // 11 RUN
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, E_RD1, 0)); // 12 redirect
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0)); // 13 stall in REDIRECT
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0)); // 14 still
      vq.push_back(v(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0)); // 15 reset mid-stall
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, E_RUN, 0)); // 16 back in RUN
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0)); // 17 RUN stall
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0)); // 18 wait cnt 1
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0)); // 19 wait cnt 2
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, E_RUN, 1)); // 20 resume, flag
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, E_RUN, 1)); // 21 sticky
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1, E_RUN, 1)); // 22 ready alone
      vq.push_back(v(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, E_STL, 1)); // 23 reset
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, E_RUN, 0)); // 24 flag cleared
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0)); // 25 -> MEM_WAIT
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, E_RD1, 0)); // 26 redirect out
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, E_RD2, 0)); // 27 REDIRECT
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0)); // 28 -> MEM_WAIT
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0)); // 29 cnt 1
      vq.push_back(v(1, 5'd4, 5'd0, 1, 0, 5'd4, 1, 1, 0, 1, 1, E_LU,  0)); // 30 lu from MEM_WAIT
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0)); // 31 -> MEM_WAIT
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0)); // 32 cnt restarts 1
      vq.push_back(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, E_RUN, 0)); // 33 no flag

      drive(vq[0]);
      @(posedge clk);
      @(posedge clk);
      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i]);
         #2;
         check($sformatf("vec%0d", i), vq[i].exp, vq[i].err);
      end

      // long stall with saturation: flag visible from the 4th stalled cycle on
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         drive(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, E_STL, 0));
         #2;
         check($sformatf("long_stall%0d", k), E_STL, (k >= 4));
      end
      @(negedge clk);
      drive(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, E_RUN, 1));
      #2;
      check("long_stall_release", E_RUN, 1'b1);

      // redirect, then REDIRECT cycle, then correct-path RUN
      @(negedge clk);
      drive(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0, E_RD1, 1));
      #2;
      check("redir_a", E_RD1, 1'b1);
      @(negedge clk);
      drive(v(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, E_RD2, 1));
      #2;
      check("redir_b", E_RD2, 1'b1);
      @(negedge clk);
      #2;
      check("redir_c", E_RUN, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
